mdu_iter: RTL and testbench

Iterative multiply/divide unit for the processor's execute stage. It accepts a 4-bit ALU control code for the multi-cycle operations MULT, MULTU, DIV and DIVU, computes the result over WIDTH+2 cycles, and writes it into the HI/LO register pair. It is the consumer of the ALU control code for long-latency operations. Single-cycle codes are not its concern.

---
 rtl/mdu_iter_pkg.sv | 26 ++
 rtl/mdu_abs_neg.sv | 13 +
 rtl/mdu_iter.sv | 172 +++++++++++++++++
 tb/tb_mdu_iter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared processor ALU definitions: control codes and
// multiply/divide unit state encoding.
package mdu_iter_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;

  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's complement: used for operand magnitude
// and for restoring the sign of products/quotients/remainders.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit writing the HI/LO pair:
// shift-add multiply, restoring divide, one bit per cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_iter_pkg::*;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2    = 2 * WIDTH;

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_busy;
  logic             r_done;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_sgn;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [W2-1:0]    w_mul_nx;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [W2-1:0]    w_div_nx;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_is_mul = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_MULTU);
  assign w_is_div = (alu_ctrl == ALU_DIV)  || (alu_ctrl == ALU_DIVU);
  assign w_sgn    = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV);
  assign w_neg_a  = w_sgn & op_a[WIDTH-1];
  assign w_neg_b  = w_sgn & op_b[WIDTH-1];

  mdu_abs_neg #(.W(WIDTH)) u_abs_a (
    .i_neg (w_neg_a),
    .i_val (op_a),
    .o_val (w_abs_a)
  );

  mdu_abs_neg #(.W(WIDTH)) u_abs_b (
    .i_neg (w_neg_b),
    .i_val (op_b),
    .o_val (w_abs_b)
  );

  // multiply: acc = {partial, multiplier}, add then shift right
  assign w_sum    = {1'b0, r_acc[W2-1:WIDTH]}
                  + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};

  // divide: acc = {remainder, dividend/quotient}, shift left
  assign w_shift  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge     = w_shift >= {1'b0, r_m};
  assign w_diff   = w_shift[WIDTH-1:0] - r_m;
  assign w_div_nx = {(w_ge ? w_diff : w_shift[WIDTH-1:0]),
                     r_acc[WIDTH-2:0], w_ge};

  mdu_abs_neg #(.W(W2)) u_fix_prod (
    .i_neg (r_neg_q),
    .i_val (r_acc),
    .o_val (w_prod)
  );

  mdu_abs_neg #(.W(WIDTH)) u_fix_quo (
    .i_neg (r_neg_q),
    .i_val (r_acc[WIDTH-1:0]),
    .o_val (w_quo)
  );

  mdu_abs_neg #(.W(WIDTH)) u_fix_rem (
    .i_neg (r_neg_r),
    .i_val (r_acc[W2-1:WIDTH]),
    .o_val (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_a_raw <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && (w_is_mul || w_is_div)) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= w_is_div;
            r_m     <= w_is_div ? w_abs_b : w_abs_a;
            r_acc   <= {{WIDTH{1'b0}},
                        (w_is_div ? w_abs_a : w_abs_b)};
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_div0  <= w_is_div && (op_b == '0);
            r_a_raw <= op_a;
          end
        end
        S_CALC: begin
          r_acc <= r_div ? w_div_nx : w_mul_nx;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!r_div) begin
            r_hi <= w_prod[W2-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: latency, busy/done framing,
// HI/LO results, ignored starts and mid-operation reset.
module tb_mdu_iter;

  import mdu_iter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  mdu_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb2 = longint'($signed(b));
    logic [63:0] r;
    r = '0;
    if (c == ALU_MULT) begin
      r = 64'(sa * sb2);
    end else if (c == ALU_MULTU) begin
      r = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (c == ALU_DIV) begin
      r = {32'(sa % sb2), 32'(sa / sb2)};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // call at a negedge in IDLE; returns at the negedge of the
  // IDLE cycle that follows DONE
  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp,
                        input bit poke);
    logic [63:0] want;
    start    = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (poke && k == 5) begin
        start    = 1'b1;
        alu_ctrl = ALU_MULTU;
        op_a     = $urandom;
        op_b     = $urandom;
      end
      if (poke && k == 6) start = 1'b0;
      chk("busy", 64'(busy), 64'd1);
      if (k < W + 2) begin
        chk("done_early", 64'(done), 64'd0);
      end else begin
        chk("done", 64'(done), 64'd1);
        want = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        chk("hi", 64'(hi), 64'(want[63:32]));
        chk("lo", 64'(lo), 64'(want[31:0]));
      end
    end
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_after", 64'(done), 64'd0);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    int dcnt;

    rst_n    = 1'b0;
    start    = 1'b0;
    alu_ctrl = 4'd0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(ALU_MULT, 32'hFFFF_FFF9, 32'd3,
           64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

    // non-MDU code must not start the unit
    start    = 1'b1;
    alu_ctrl = 4'b0010;
    op_a     = 32'd12;
    op_b     = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ign_busy", 64'(busy), 64'd0);
      chk("ign_done", 64'(done), 64'd0);
    end
    start = 1'b0;
    chk("ign_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("ign_lo", 64'(lo), 64'hFFFF_FFFD);

    run_op(ALU_DIVU, 32'd100, 32'd0,
           64'h0000_0064_FFFF_FFFF, 1'b0);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, 1'b0);
    run_op(ALU_DIV, 32'hFFFF_FFFB, 32'd0,
           64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    run_op(ALU_MULTU, 32'd123456, 32'd789,
           64'd97406784, 1'b1);

    for (int i = 0; i < 8; i++) begin
      c = 4'(8 + (i % 4));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 30);
      if (i >= 4 && (c == ALU_MULT || c == ALU_DIV)) b = -b;
      run_op(c, a, b, model(c, a, b), 1'b0);
    end

    // abort a DIVU partway through
    start    = 1'b1;
    alu_ctrl = ALU_DIVU;
    op_a     = 32'd1000;
    op_b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
